// File: rtl/cfg_chain_loader.sv
// Loads NUM_WORDS config words into an scff scan chain MSB first, then strobes cfg_latch
// to commit the LUT config shadow. All outputs come straight from flops.
module cfg_chain_loader #(
  parameter int unsigned NUM_WORDS    = 8,
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned LATCH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              sc_dout,
  output logic              sc_shift,
  output logic              cfg_latch,
  output logic              busy,
  output logic              done,
  output logic [7:0]        word_cnt
);

  localparam int unsigned BitW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StShift, StLatch, StDone} state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic [7:0]          word_cnt_q, word_cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                sc_dout_q, sc_dout_d;
  logic                sc_shift_q, sc_shift_d;
  logic                cfg_latch_q, cfg_latch_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                active;

  assign active = (state_q == StFetch) || (state_q == StShift) || (state_q == StLatch);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    word_cnt_d = word_cnt_q;

    // Abort outranks every in-state transition, including word capture in FETCH.
    if (abort && active) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StFetch;
            word_cnt_d = '0;
          end
        end
        StFetch: begin
          if (in_valid && in_ready_q) begin
            shreg_d   = in_data;
            bit_cnt_d = '0;
            state_d   = StShift;
          end
        end
        StShift: begin
          shreg_d = shreg_q << 1;
          if (bit_cnt_q == BitW'(WORD_W - 1)) begin
            if (word_cnt_q != 8'hFF) word_cnt_d = word_cnt_q + 8'd1;
            if (word_cnt_q == 8'(NUM_WORDS - 1)) begin
              state_d   = StLatch;
              lat_cnt_d = '0;
            end else begin
              state_d = StFetch;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StLatch: begin
          if (lat_cnt_q == 4'(LATCH_CYCLES - 1)) state_d = StDone;
          else lat_cnt_d = lat_cnt_q + 4'd1;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // Output flops are loaded from the next state so they line up with the state register.
    in_ready_d  = (state_d == StFetch);
    sc_shift_d  = (state_d == StShift);
    sc_dout_d   = sc_shift_d & shreg_d[WORD_W-1];
    cfg_latch_d = (state_d == StLatch);
    busy_d      = (state_d == StFetch) || (state_d == StShift) || (state_d == StLatch);
    done_d      = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      word_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      sc_dout_q   <= 1'b0;
      sc_shift_q  <= 1'b0;
      cfg_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      word_cnt_q  <= word_cnt_d;
      in_ready_q  <= in_ready_d;
      sc_dout_q   <= sc_dout_d;
      sc_shift_q  <= sc_shift_d;
      cfg_latch_q <= cfg_latch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign sc_dout   = sc_dout_q;
  assign sc_shift  = sc_shift_q;
  assign cfg_latch = cfg_latch_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign word_cnt  = word_cnt_q;

endmodule
